// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button debounce slice.
package btn_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'b00,
        S_WAIT_HIGH = 2'b01,
        S_HIGH      = 2'b11,
        S_WAIT_LOW  = 2'b10
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYC = 20000;
    localparam int DEF_LONG_CYC     = 1000000;
    localparam int SIM_DEBOUNCE_CYC = 4;

endpackage

// File: rtl/sync_ff.sv
// SYNC_STAGES-deep flop chain bringing an asynchronous pin into the clk domain.
module sync_ff #(
    parameter int SYNC_STAGES = 2,
    parameter bit RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchroniser plus stability-counter FSM producing Level.
// Optional long-press indicator enabled by defining DEBOUNCE_LONGPRESS_EN.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int CNT_W        = 16,
    parameter bit ACTIVE_LOW   = 1'b0
`ifdef DEBOUNCE_LONGPRESS_EN
    ,
    parameter int LONG_CYC     = DEF_LONG_CYC
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic Level,
    output logic busy
`ifdef DEBOUNCE_LONGPRESS_EN
    ,
    output logic long_hold
`endif
);

    // The entry edge into a WAIT state is the first stable sample, so the
    // last counted sample lands at DEBOUNCE_CYC-2 on the counter.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 2);

    logic             btn_sync;
    logic             btn_s;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Reset value is the released pin level, so btn_s resets to 0.
    sync_ff #(
        .SYNC_STAGES(SYNC_STAGES),
        .RST_VAL    (ACTIVE_LOW)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (btn_raw),
        .q  (btn_sync)
    );

    assign btn_s = btn_sync ^ ACTIVE_LOW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LOW;
            cnt   <= '0;
            Level <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                S_LOW: begin
                    if (btn_s) begin
                        state <= S_WAIT_HIGH;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (!btn_s) begin
                        state <= S_LOW;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                        Level <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (!btn_s) begin
                        state <= S_WAIT_LOW;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_WAIT_LOW: begin
                    if (btn_s) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_LOW;
                        cnt   <= '0;
                        Level <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_LOW;
                    cnt   <= '0;
                    Level <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int               HOLD_W   = $clog2(LONG_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYC - 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              level_fall;

    // long_hold must drop on the same edge Level does, so look ahead.
    assign level_fall = (state == S_WAIT_LOW) && !btn_s && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt  <= '0;
            long_hold <= 1'b0;
        end else if (!Level || level_fall) begin
            hold_cnt  <= '0;
            long_hold <= 1'b0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HOLD_PRE) begin
                long_hold <= 1'b1;
            end
        end
    end
`endif

endmodule
